stage_mem_ctrl: RTL
===================

Name: stage_mem_ctrl

Overview:
Control-plane sequencer for port B of one lookup-stage block RAM (true dual-port, 1-cycle registered read). Port A stays dedicated to the lookup pipeline. This block accepts single-word read and write commands plus a range-fill command from the table-update path, and drives the RAM port B signals. It returns read data through a one-entry response register with valid/ready flow control.

Parameters:
STAGE_ID, 0, stage index; used only in simulation messages
DATA, 72, RAM word width
ADDR, 10, RAM address width; depth is 2**ADDR

Ports:
clk  in  1  single clock; RAM port B clock tied to the same net
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_op  in  2  00 read, 01 write, 10 fill, 11 illegal
cmd_addr  in  ADDR  word address; fill start address
cmd_len  in  ADDR  fill only: number of words minus 1
cmd_data  in  DATA  write or fill value
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer takes rsp_data
rsp_data  out  DATA  read result
fill_done  out  1  one-cycle pulse after the last fill write
cmd_err  out  1  one-cycle pulse on an accepted illegal op
busy  out  1  high whenever state != IDLE
mem_wr  out  1  to RAM b_wr (registered)
mem_addr  out  ADDR  to RAM b_addr (registered)
mem_din  out  DATA  to RAM b_din (registered)
mem_dout  in  DATA  from RAM b_dout

Behaviour:
- Reset values: all outputs 0, rsp_data 0, state IDLE. cmd_ready is 0 during reset; it becomes 1 on the first cycle after rst deasserts.
- States: IDLE, RD1, RD2, FILL.
- cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready). Combinational, not dependent on cmd_op.
- Write, accepted at edge T:
  - mem_wr=1, mem_addr=cmd_addr, mem_din=cmd_data after T; mem_wr returns to 0 after T+1 unless another write is accepted.
  - State stays IDLE, so back-to-back writes sustain 1 per cycle.
- Read, accepted at edge T:
  - mem_addr=cmd_addr, mem_wr=0 after T; state goes RD1.
  - RAM samples at T+1; state goes RD2.
  - At T+2, rsp_data<=mem_dout and rsp_valid<=1; state returns to IDLE.
  - Command-to-rsp_valid latency is exactly 2 cycles. No new command is accepted during RD1/RD2.
- Response: rsp_valid stays high, and rsp_data stays stable, until rsp_valid && rsp_ready. If a read is accepted on the same edge the old response drains, the old response clears and the new one appears at T+2.
- Fill, accepted at T:
  - Latch start=cmd_addr, remaining=cmd_len, value=cmd_data; state goes FILL.
  - Each FILL cycle registers mem_wr=1 with the current address; the address increments modulo 2**ADDR (wraps from 2**ADDR-1 to 0).
  - Exactly cmd_len+1 writes are issued on consecutive cycles, covering 1..2**ADDR words.
  - After the final write edge, state goes IDLE and fill_done pulses for 1 cycle, in the same cycle mem_wr deasserts.
- Illegal op 11: accepted (ready obeys the normal rule). cmd_err pulses the next cycle; no RAM access; state unchanged.
- Lookup port A is never stalled by this block. A same-address collision between port A read and a port B write returns old data on port A (read-first); this is documented, not prevented.
- Reset mid-operation:
  - rst during FILL or RD1/RD2 aborts. mem_wr is 0 and state is IDLE after the reset edge.
  - No fill_done or rsp_valid is produced; memory is left partially written.

Optional Feature:
STAGE_MEM_CTRL_FILL_EN
- Defined: fill op and FILL state are present as described.
- Undefined: op 10 is treated exactly as illegal (cmd_err pulse, no RAM access). The FILL state, counter and fill_done logic are removed, and fill_done is tied to 0.

Decomposition:
- Package stage_mem_ctrl_pkg holds:
  - op encoding constants OP_READ, OP_WRITE, OP_FILL, OP_ILLEGAL;
  - state enum type;
  - READ_LATENCY=2.
- No sub-module. The fill counter and response register are small enough to stay inline. The RAM itself is instantiated by the parent stage, not here.

Test Plan:
- Write 0x0AB at addr 5, then read addr 5 with rsp_ready=1: rsp_valid exactly 2 cycles after read accept, rsp_data=0x0AB.
- Four back-to-back writes to addrs 0..3 (data 1..4): cmd_ready held 1, mem_wr high 4 consecutive cycles; readback returns 1..4.
- Read with rsp_ready=0 for 5 cycles: rsp_valid and rsp_data stable, cmd_ready=0 throughout. Raise rsp_ready together with a new read of another address: new data appears 2 cycles later.
- Fill start=1022, len=3, data=0xFF (ADDR=10): writes at 1022, 1023, 0, 1, fill_done 1 cycle after the 4th write; addr 2 is unchanged.
- Fill len=1023 with rst asserted on the 10th fill cycle: mem_wr=0 next cycle, no fill_done, busy=0. Words 0..8 are written; word 9 and later are unchanged.
- op=11: cmd_err pulses once, no mem_wr. With STAGE_MEM_CTRL_FILL_EN undefined, op=10 behaves identically.

Source files
------------

// File: rtl/stage_mem_ctrl_pkg.sv
// Shared op encodings, FSM state type and timing constants for the
// port-B control sequencer of a lookup-stage block RAM.
package stage_mem_ctrl_pkg;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_FILL    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int READ_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2,
        ST_FILL = 2'd3
    } state_e;

endpackage

// File: rtl/stage_mem_ctrl.sv
// Port-B sequencer for one lookup-stage RAM: single reads/writes plus range fill.
// Range fill is built only when STAGE_MEM_CTRL_FILL_EN is defined.
module stage_mem_ctrl
    import stage_mem_ctrl_pkg::*;
#(
    parameter int STAGE_ID = 0,
    parameter int DATA     = 72,
    parameter int ADDR     = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [ADDR-1:0] cmd_addr,
    input  logic [ADDR-1:0] cmd_len,
    input  logic [DATA-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DATA-1:0] rsp_data,
    output logic            fill_done,
    output logic            cmd_err,
    output logic            busy,
    output logic            mem_wr,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_din,
    input  logic [DATA-1:0] mem_dout
);

    localparam int unused_stage = STAGE_ID;

    state_e          state_q, state_d;
    logic            mem_wr_q, mem_wr_d;
    logic [ADDR-1:0] mem_addr_q, mem_addr_d;
    logic [DATA-1:0] mem_din_q, mem_din_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DATA-1:0] rsp_data_q, rsp_data_d;
    logic            cmd_err_q, cmd_err_d;
    logic            accept;

`ifdef STAGE_MEM_CTRL_FILL_EN
    logic [ADDR-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR-1:0] fill_rem_q, fill_rem_d;
    logic [DATA-1:0] fill_val_q, fill_val_d;
    logic            fill_last_q, fill_last_d;
    logic            fill_done_q;
`else
    logic            unused_len;
    assign unused_len = ^cmd_len;
`endif

    assign cmd_ready = !rst && (state_q == ST_IDLE)
                     && (!rsp_valid_q || rsp_ready);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cmd_err_q   <= 1'b0;
`ifdef STAGE_MEM_CTRL_FILL_EN
            fill_addr_q <= '0;
            fill_rem_q  <= '0;
            fill_val_q  <= '0;
            fill_last_q <= 1'b0;
            fill_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cmd_err_q   <= cmd_err_d;
`ifdef STAGE_MEM_CTRL_FILL_EN
            fill_addr_q <= fill_addr_d;
            fill_rem_q  <= fill_rem_d;
            fill_val_q  <= fill_val_d;
            fill_last_q <= fill_last_d;
            // Pulse lines up with the cycle the last write lands in the RAM
            fill_done_q <= fill_last_q;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_data_d  = rsp_data_q;
        cmd_err_d   = 1'b0;
`ifdef STAGE_MEM_CTRL_FILL_EN
        fill_addr_d = fill_addr_q;
        fill_rem_d  = fill_rem_q;
        fill_val_d  = fill_val_q;
        fill_last_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_READ: begin
                            mem_addr_d = cmd_addr;
                            state_d    = ST_RD1;
                        end
                        OP_WRITE: begin
                            mem_wr_d   = 1'b1;
                            mem_addr_d = cmd_addr;
                            mem_din_d  = cmd_data;
                        end
`ifdef STAGE_MEM_CTRL_FILL_EN
                        OP_FILL: begin
                            fill_addr_d = cmd_addr;
                            fill_rem_d  = cmd_len;
                            fill_val_d  = cmd_data;
                            state_d     = ST_FILL;
                        end
`endif
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            ST_RD1: state_d = ST_RD2;
            ST_RD2: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_dout;
                state_d     = ST_IDLE;
            end
`ifdef STAGE_MEM_CTRL_FILL_EN
            ST_FILL: begin
                mem_wr_d    = 1'b1;
                mem_addr_d  = fill_addr_q;
                mem_din_d   = fill_val_q;
                fill_addr_d = fill_addr_q + ADDR'(1);
                fill_rem_d  = fill_rem_q - ADDR'(1);
                if (fill_rem_q == '0) begin
                    fill_last_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign cmd_err   = cmd_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
`ifdef STAGE_MEM_CTRL_FILL_EN
    assign fill_done = fill_done_q;
`else
    assign fill_done = 1'b0;
`endif

endmodule
